// File: rtl/axi_sim_pkg.sv
// Shared encodings for the AXI4 simulation memory: burst types, response codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_sim_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_e;

    // Reserved burst encoding: advances like INCR but every beat answers SLVERR.
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_BURST
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_LAT,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/axi_sim_burst_addr.sv
// Beat address step (FIXED/INCR/WRAP) plus per-beat legality check for one AXI channel.
// Latency: purely combinational.
// Backpressure: none; the owning engine decides when to consume next_addr.
module axi_sim_burst_addr
    import axi_sim_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       STRB_W    = 4,
    parameter int unsigned       MEM_BYTES = 65536,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
    parameter logic [ADDR_W-1:0] PUTC_ADDR = 'hA000_03F8
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              addr_err,
    output logic              putc_hit
);

`ifdef AXI_SIM_MEM_PUTC_EN
    localparam bit PUTC_EN = 1'b1;
`else
    localparam bit PUTC_EN = 1'b0;
`endif

    localparam logic [2:0]        SIZE_MAX = 3'($clog2(STRB_W));
    localparam logic [ADDR_W-1:0] MEM_SPAN = ADDR_W'(MEM_BYTES);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] offset;
    logic              in_range;

    // Next beat address and legality of the current beat.
    always_comb begin
        step      = ADDR_W'(1) << size;
        // Wrap container is (len+1) beats of (1<<size) bytes, aligned to its own size.
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        incr_addr = addr + step;
        offset    = addr - BASE_ADDR;
        in_range  = (addr >= BASE_ADDR) && (offset < MEM_SPAN);
        case (burst)
            FIXED:   next_addr = addr;
            WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = incr_addr;
        endcase
        putc_hit = PUTC_EN && (addr == PUTC_ADDR);
        addr_err = (!in_range && !putc_hit) || (size > SIZE_MAX) || (burst == BURST_RSVD);
    end

endmodule

// File: rtl/axi_sim_mem.sv
// AXI4 slave memory model with independent read/write engines, one burst each (console option: AXI_SIM_MEM_PUTC_EN).
// Latency: first R beat RD_LAT+1 cycles after AR handshake; B valid WR_LAT cycles after the last W beat.
// Backpressure: r_valid/r_data hold while r_ready is low; b_valid holds until b_ready; W stalls until AW is taken.
module axi_sim_mem
    import axi_sim_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ID_W      = 4,
    parameter int unsigned       MEM_BYTES = 65536,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
    parameter int unsigned       RD_LAT    = 2,
    parameter int unsigned       WR_LAT    = 1,
    parameter logic [ADDR_W-1:0] PUTC_ADDR = 'hA000_03F8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                aw_valid,
    output logic                aw_ready,
    input  logic [ADDR_W-1:0]   aw_addr,
    input  logic [ID_W-1:0]     aw_id,
    input  logic [7:0]          aw_len,
    input  logic [2:0]          aw_size,
    input  logic [1:0]          aw_burst,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic                w_last,
    output logic                b_valid,
    input  logic                b_ready,
    output logic [1:0]          b_resp,
    output logic [ID_W-1:0]     b_id,
    input  logic                ar_valid,
    output logic                ar_ready,
    input  logic [ADDR_W-1:0]   ar_addr,
    input  logic [ID_W-1:0]     ar_id,
    input  logic [7:0]          ar_len,
    input  logic [2:0]          ar_size,
    input  logic [1:0]          ar_burst,
    output logic                r_valid,
    input  logic                r_ready,
    output logic [DATA_W-1:0]   r_data,
    output logic [1:0]          r_resp,
    output logic                r_last,
    output logic [ID_W-1:0]     r_id
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned WORDS  = MEM_BYTES / STRB_W;
    localparam int unsigned WORD_W = $clog2(WORDS);
    localparam int unsigned LSB_W  = $clog2(STRB_W);

    // Backing store is never reset so contents survive a mid-burst reset.
    logic [DATA_W-1:0] mem [WORDS];

    function automatic logic [WORD_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return WORD_W'((a - BASE_ADDR) >> LSB_W);
    endfunction

    // ---------------- read engine ----------------
    rd_state_e         rd_state, rd_next;
    logic [ADDR_W-1:0] rd_addr, rd_step_addr;
    logic [7:0]        rd_len, rd_beat;
    logic [2:0]        rd_size;
    logic [1:0]        rd_burst;
    logic [3:0]        rd_lat;
    logic              rd_err, rd_putc, rd_load;

    axi_sim_burst_addr #(
        .ADDR_W(ADDR_W), .STRB_W(STRB_W), .MEM_BYTES(MEM_BYTES),
        .BASE_ADDR(BASE_ADDR), .PUTC_ADDR(PUTC_ADDR)
    ) u_ar_addr (
        .addr(rd_addr), .len(rd_len), .size(rd_size), .burst(rd_burst),
        .next_addr(rd_step_addr), .addr_err(rd_err), .putc_hit(rd_putc)
    );

    assign ar_ready = !reset && (rd_state == R_IDLE);

    // Read state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rd_state <= R_IDLE;
        else       rd_state <= rd_next;
    end

    // Read next state; a beat is loaded whenever the output slot is empty or being drained mid-burst.
    always_comb begin
        rd_next = rd_state;
        rd_load = 1'b0;
        case (rd_state)
            R_IDLE:  if (ar_valid && ar_ready) rd_next = (RD_LAT == 0) ? R_BURST : R_WAIT;
            R_WAIT:  if (rd_lat == 4'(RD_LAT - 1)) rd_next = R_BURST;
            R_BURST: begin
                if (r_valid && r_ready && r_last) rd_next = R_IDLE;
                else if (!r_valid || r_ready)     rd_load = 1'b1;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // Read burst context and registered R channel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_size  <= '0;
            rd_burst <= '0;
            rd_beat  <= '0;
            rd_lat   <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_resp   <= RESP_OKAY;
            r_last   <= 1'b0;
            r_id     <= '0;
        end else begin
            if (rd_state == R_IDLE && ar_valid && ar_ready) begin
                rd_addr  <= ar_addr;
                rd_len   <= ar_len;
                rd_size  <= ar_size;
                rd_burst <= ar_burst;
                rd_beat  <= '0;
                rd_lat   <= '0;
                r_id     <= ar_id;
            end
            if (rd_state == R_WAIT) rd_lat <= rd_lat + 4'd1;
            if (rd_load) begin
                r_valid <= 1'b1;
                r_data  <= (rd_err || rd_putc) ? '0 : mem[word_idx(rd_addr)];
                r_resp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                r_last  <= (rd_beat == rd_len);
                rd_addr <= rd_step_addr;
                rd_beat <= rd_beat + 8'd1;
            end else if (r_valid && r_ready) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    // ---------------- write engine ----------------
    wr_state_e         wr_state, wr_next;
    logic [ADDR_W-1:0] wr_addr, wr_step_addr;
    logic [7:0]        wr_len, wr_beat;
    logic [2:0]        wr_size;
    logic [1:0]        wr_burst;
    logic [3:0]        wr_lat;
    logic              wr_addr_err, wr_putc, wr_take, beat_last, beat_err;

    axi_sim_burst_addr #(
        .ADDR_W(ADDR_W), .STRB_W(STRB_W), .MEM_BYTES(MEM_BYTES),
        .BASE_ADDR(BASE_ADDR), .PUTC_ADDR(PUTC_ADDR)
    ) u_aw_addr (
        .addr(wr_addr), .len(wr_len), .size(wr_size), .burst(wr_burst),
        .next_addr(wr_step_addr), .addr_err(wr_addr_err), .putc_hit(wr_putc)
    );

    assign aw_ready  = !reset && (wr_state == W_IDLE);
    assign w_ready   = (wr_state == W_DATA);
    assign b_valid   = (wr_state == W_RESP);
    assign beat_last = (wr_beat == wr_len);
    assign beat_err  = wr_addr_err || (w_last != beat_last);

    // Write state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) wr_state <= W_IDLE;
        else       wr_state <= wr_next;
    end

    // Write next state; the burst closes on w_last or on the final counted beat, whichever comes first.
    always_comb begin
        wr_next = wr_state;
        wr_take = 1'b0;
        case (wr_state)
            W_IDLE: if (aw_valid && aw_ready) wr_next = W_DATA;
            W_DATA: if (w_valid) begin
                wr_take = 1'b1;
                if (w_last || beat_last) wr_next = (WR_LAT == 0) ? W_RESP : W_LAT;
            end
            W_LAT:  if (wr_lat == 4'(WR_LAT - 1)) wr_next = W_RESP;
            W_RESP: if (b_ready) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    // Write burst context and sticky B response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_size  <= '0;
            wr_burst <= '0;
            wr_beat  <= '0;
            wr_lat   <= '0;
            b_resp   <= RESP_OKAY;
            b_id     <= '0;
        end else begin
            if (wr_state == W_IDLE && aw_valid && aw_ready) begin
                wr_addr  <= aw_addr;
                wr_len   <= aw_len;
                wr_size  <= aw_size;
                wr_burst <= aw_burst;
                wr_beat  <= '0;
                wr_lat   <= '0;
                b_resp   <= RESP_OKAY;
                b_id     <= aw_id;
            end
            if (wr_state == W_LAT) wr_lat <= wr_lat + 4'd1;
            if (wr_take) begin
                wr_addr <= wr_step_addr;
                wr_beat <= wr_beat + 8'd1;
                if (beat_err) b_resp <= RESP_SLVERR;
            end
        end
    end

    // Byte-strobed store of accepted, legal beats; the console address is never stored.
    always_ff @(posedge clock) begin
        if (wr_take && !beat_err && !wr_putc) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
`ifdef AXI_SIM_MEM_PUTC_EN
        if (wr_take && wr_putc && w_strb[0]) $write("%c", w_data[7:0]);
`endif
    end

endmodule

// File: tb/tb_axi_sim_mem.sv
// Directed bench for axi_sim_mem: reset, INCR/WRAP/FIXED reads, strobed writes, error and console paths.
// Latency: checks first-R and B timing against RD_LAT=2 / WR_LAT=1.
// Backpressure: exercises r_ready toggling and mid-burst reset.
module tb_axi_sim_mem;
    import axi_sim_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        aw_valid = 0, aw_ready;
    logic [31:0] aw_addr = '0;
    logic [3:0]  aw_id = '0;
    logic [7:0]  aw_len = '0;
    logic [2:0]  aw_size = '0;
    logic [1:0]  aw_burst = '0;
    logic        w_valid = 0, w_ready;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        w_last = 0;
    logic        b_valid, b_ready = 0;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic        ar_valid = 0, ar_ready;
    logic [31:0] ar_addr = '0;
    logic [3:0]  ar_id = '0;
    logic [7:0]  ar_len = '0;
    logic [2:0]  ar_size = '0;
    logic [1:0]  ar_burst = '0;
    logic        r_valid, r_ready = 0;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [3:0]  r_id;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] wdat  [16];
    logic [3:0]  wstrb [16];
    logic [31:0] rdat  [16];
    logic [1:0]  rresp [16];
    logic        rlast [16];
    logic [3:0]  rid_seen, bid_seen;

    axi_sim_mem #(
        .ADDR_W(32), .DATA_W(32), .ID_W(4), .MEM_BYTES(65536),
        .BASE_ADDR(32'h8000_0000), .RD_LAT(2), .WR_LAT(1), .PUTC_ADDR(32'hA000_03F8)
    ) dut (
        .clock(clock), .reset(reset),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .r_last(r_last), .r_id(r_id)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic timeout(input string what);
        vectors++;
        miscompares++;
        $display("FAIL timeout_%s: handshake not seen within bound, required within bound", what);
    endtask

    // Drives one write burst; beats stop early if last_at < len (early w_last).
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input int last_at, output logic [1:0] resp, output int blat);
        int n;
        int nb;
        aw_valid = 1; aw_addr = addr; aw_len = len; aw_size = 3'd2; aw_burst = burst; aw_id = 4'h5;
        n = 0;
        while (!aw_ready && n < 100) begin tick(); n++; end
        if (n >= 100) timeout("aw");
        tick();
        aw_valid = 0;
        nb = (last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
        for (int i = 0; i < nb; i++) begin
            w_valid = 1; w_data = wdat[i]; w_strb = wstrb[i]; w_last = (i == last_at);
            n = 0;
            while (!w_ready && n < 100) begin tick(); n++; end
            if (n >= 100) timeout("w");
            tick();
        end
        w_valid = 0; w_last = 0;
        blat = 0;
        while (!b_valid && blat < 100) begin tick(); blat++; end
        if (blat >= 100) timeout("b");
        resp = b_resp;
        bid_seen = b_id;
        b_ready = 1;
        tick();
        b_ready = 0;
    endtask

    // Issues one read burst and collects beats; toggle alternates r_ready every cycle.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input bit toggle,
                           output int first_lat, output int nb, output int holds_bad);
        int n;
        logic stalled;
        logic [31:0] held;
        for (int i = 0; i < 16; i++) begin rdat[i] = 'x; rresp[i] = 'x; rlast[i] = 'x; end
        ar_valid = 1; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = 4'hA;
        n = 0;
        while (!ar_ready && n < 100) begin tick(); n++; end
        if (n >= 100) timeout("ar");
        tick();
        ar_valid = 0;
        first_lat = -1; nb = 0; holds_bad = 0; stalled = 0; held = '0; n = 0;
        r_ready = 1;
        while (nb <= int'(len) && n < 200) begin
            if (r_valid && first_lat < 0) begin first_lat = n; rid_seen = r_id; end
            if (stalled && (!r_valid || r_data !== held)) holds_bad++;
            if (r_valid && r_ready) begin
                rdat[nb] = r_data; rresp[nb] = r_resp; rlast[nb] = r_last; nb++;
            end
            stalled = r_valid && !r_ready;
            held = r_data;
            tick();
            n++;
            if (toggle) r_ready = ~r_ready;
        end
        if (n >= 200) timeout("r");
        r_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        tick(); tick(); tick();
        vectors++;
        if ({aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last, r_data, r_resp, b_resp, r_id, b_id} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got rdy/vld %b%b%b%b%b data %h, want all zero",
                     aw_ready, ar_ready, w_ready, b_valid, r_valid, r_data);
        end
        reset = 0;
        #1;
        vectors++;
        if ({aw_ready, ar_ready, w_ready, b_valid, r_valid} !== 5'b11000) begin
            miscompares++;
            $display("FAIL reset_release: got aw/ar/w/b/r %b, want 11000",
                     {aw_ready, ar_ready, w_ready, b_valid, r_valid});
        end
        tick();
    endtask

    task automatic test_preload();
        logic [1:0] resp;
        int blat;
        wdat[0] = 32'h1122_3344;
        for (int i = 1; i < 16; i++) wdat[i] = 32'hC0DE_0000 + 32'(4 * i);
        for (int i = 0; i < 16; i++) wstrb[i] = 4'hF;
        do_write(32'h8000_0000, 8'd8, INCR, 8, resp, blat);
        vectors++;
        if (resp !== RESP_OKAY || bid_seen !== 4'h5) begin
            miscompares++;
            $display("FAIL preload_b: got resp %b id %h, want 00 id 5", resp, bid_seen);
        end
        vectors++;
        if (blat !== 1) begin
            miscompares++;
            $display("FAIL preload_b_latency: got %0d, want 1", blat);
        end
    endtask

    task automatic test_incr_read();
        int lat, nb, hb;
        logic [31:0] exp;
        do_read(32'h8000_0010, 8'd3, INCR, 3'd2, 1'b0, lat, nb, hb);
        vectors++;
        if (lat !== 3 || nb !== 4) begin
            miscompares++;
            $display("FAIL incr_timing: got first %0d beats %0d, want 3 and 4", lat, nb);
        end
        vectors++;
        if (rid_seen !== 4'hA) begin
            miscompares++;
            $display("FAIL incr_rid: got %h, want a", rid_seen);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 32'hC0DE_0010 + 32'(4 * i);
            vectors++;
            if (rdat[i] !== exp || rresp[i] !== RESP_OKAY || rlast[i] !== (i == 3)) begin
                miscompares++;
                $display("FAIL incr_beat%0d: got %h/%b/%b, want %h/00/%b", i, rdat[i], rresp[i], rlast[i], exp, i == 3);
            end
        end
    endtask

    task automatic test_strobe_write();
        logic [1:0] resp;
        int blat, lat, nb, hb;
        wdat[0] = 32'hDEAD_BEEF;
        wstrb[0] = 4'b0011;
        do_write(32'h8000_0000, 8'd0, INCR, 0, resp, blat);
        wstrb[0] = 4'hF;
        vectors++;
        if (resp !== RESP_OKAY || blat !== 1) begin
            miscompares++;
            $display("FAIL strobe_b: got resp %b lat %0d, want 00 lat 1", resp, blat);
        end
        do_read(32'h8000_0000, 8'd0, INCR, 3'd2, 1'b0, lat, nb, hb);
        vectors++;
        if (rdat[0] !== 32'h1122_BEEF || rlast[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL strobe_readback: got %h last %b, want 1122beef last 1", rdat[0], rlast[0]);
        end
    endtask

    task automatic test_wrap_read();
        int lat, nb, hb;
        logic [31:0] exp [4];
        exp[0] = 32'hC0DE_0008; exp[1] = 32'hC0DE_000C; exp[2] = 32'h1122_BEEF; exp[3] = 32'hC0DE_0004;
        do_read(32'h8000_0008, 8'd3, WRAP, 3'd2, 1'b1, lat, nb, hb);
        vectors++;
        if (hb !== 0 || nb !== 4) begin
            miscompares++;
            $display("FAIL wrap_hold: got %0d hold violations %0d beats, want 0 and 4", hb, nb);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rdat[i] !== exp[i] || rlast[i] !== (i == 3)) begin
                miscompares++;
                $display("FAIL wrap_beat%0d: got %h last %b, want %h last %b", i, rdat[i], rlast[i], exp[i], i == 3);
            end
        end
    endtask

    task automatic test_fixed_read();
        int lat, nb, hb;
        do_read(32'h8000_0010, 8'd2, FIXED, 3'd2, 1'b0, lat, nb, hb);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rdat[i] !== 32'hC0DE_0010) begin
                miscompares++;
                $display("FAIL fixed_beat%0d: got %h, want c0de0010", i, rdat[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp;
        int blat, lat, nb, hb;
        do_read(32'h7FFF_FFFC, 8'd0, INCR, 3'd2, 1'b0, lat, nb, hb);
        vectors++;
        if (rresp[0] !== RESP_SLVERR || rdat[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL below_base: got %b/%h, want 10/00000000", rresp[0], rdat[0]);
        end
        do_read(32'h8001_0000, 8'd0, INCR, 3'd2, 1'b0, lat, nb, hb);
        vectors++;
        if (rresp[0] !== RESP_SLVERR || rdat[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL above_top: got %b/%h, want 10/00000000", rresp[0], rdat[0]);
        end
        do_read(32'h8000_FFFC, 8'd0, INCR, 3'd2, 1'b0, lat, nb, hb);
        vectors++;
        if (rresp[0] !== RESP_OKAY) begin
            miscompares++;
            $display("FAIL top_word: got %b, want 00", rresp[0]);
        end
        do_read(32'h8000_0000, 8'd0, INCR, 3'd3, 1'b0, lat, nb, hb);
        vectors++;
        if (rresp[0] !== RESP_SLVERR || rdat[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL oversize: got %b/%h, want 10/00000000", rresp[0], rdat[0]);
        end
        wdat[0] = 32'hBADB_AD00;
        do_write(32'h8000_0020, 8'd1, INCR, 0, resp, blat);
        wdat[0] = 32'h1122_3344;
        vectors++;
        if (resp !== RESP_SLVERR) begin
            miscompares++;
            $display("FAIL early_wlast: got %b, want 10", resp);
        end
        do_read(32'h8000_0020, 8'd0, INCR, 3'd2, 1'b0, lat, nb, hb);
        vectors++;
        if (rdat[0] !== 32'hC0DE_0020) begin
            miscompares++;
            $display("FAIL dropped_write: got %h, want c0de0020", rdat[0]);
        end
    endtask

    task automatic test_putc();
        logic [1:0] resp, exp_resp;
        int blat, lat, nb, hb;
`ifdef AXI_SIM_MEM_PUTC_EN
        exp_resp = RESP_OKAY;
`else
        exp_resp = RESP_SLVERR;
`endif
        wdat[0] = 32'h0000_0041;
        do_write(32'hA000_03F8, 8'd0, INCR, 0, resp, blat);
        vectors++;
        if (resp !== exp_resp) begin
            miscompares++;
            $display("FAIL putc_write: got %b, want %b", resp, exp_resp);
        end
        do_read(32'hA000_03F8, 8'd0, INCR, 3'd2, 1'b0, lat, nb, hb);
        vectors++;
        if (rresp[0] !== exp_resp || rdat[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL putc_read: got %b/%h, want %b/00000000", rresp[0], rdat[0], exp_resp);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n, nb, lat, hb;
        ar_valid = 1; ar_addr = 32'h8000_0000; ar_len = 8'd7; ar_size = 3'd2; ar_burst = INCR; ar_id = 4'h3;
        n = 0;
        while (!ar_ready && n < 100) begin tick(); n++; end
        if (n >= 100) timeout("rst_ar");
        tick();
        ar_valid = 0;
        r_ready = 1;
        nb = 0; n = 0;
        while (nb < 2 && n < 100) begin
            if (r_valid) nb++;
            tick();
            n++;
        end
        if (n >= 100) timeout("rst_r");
        vectors++;
        if (r_valid !== 1'b1 || r_data !== 32'hC0DE_0008) begin
            miscompares++;
            $display("FAIL beat2_before_reset: got vld %b data %h, want 1 c0de0008", r_valid, r_data);
        end
        reset = 1;
        tick();
        vectors++;
        if (r_valid !== 1'b0 || ar_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL in_reset: got r_valid %b ar_ready %b, want 0 0", r_valid, ar_ready);
        end
        reset = 0;
        #1;
        vectors++;
        if (ar_ready !== 1'b1 || r_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset: got ar_ready %b r_valid %b, want 1 0", ar_ready, r_valid);
        end
        tick(); tick();
        vectors++;
        if (r_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abandoned_burst: got r_valid %b, want 0", r_valid);
        end
        r_ready = 0;
        do_read(32'h8000_0010, 8'd0, INCR, 3'd2, 1'b0, lat, nb, hb);
        vectors++;
        if (rdat[0] !== 32'hC0DE_0010) begin
            miscompares++;
            $display("FAIL mem_retained: got %h, want c0de0010", rdat[0]);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_incr_read();
        test_strobe_write();
        test_wrap_read();
        test_fixed_read();
        test_errors();
        test_putc();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
